game_input_conditioner: RTL

- Conditions the raw board button and two slide switches before they enter the game top level.
- Synchronises the raw inputs and debounces them, then presents clean levels plus single-cycle event pulses.
- Generates a hold-to-repeat pulse for the fire key.
- Sits directly upstream of the game top level: its key/sw outputs drive the master FSM key input and the torpedo dx/dy select.

---
 rtl/game_input_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/game_input_conditioner.sv
// rtl/game_input_conditioner.sv - synchronise, debounce and auto-repeat the board key and slide switches
module game_input_conditioner #(
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int CNT_WIDTH       = 25,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_raw,
  input  logic [1:0] sw_raw,
  output logic       key,
  output logic       key_pressed,
  output logic       key_released,
  output logic       key_repeat,
  output logic [1:0] sw,
  output logic       sw_changed
);

  // Raw key level when the button is not pressed; also the synchroniser reset value.
  localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0);
  localparam logic [2:0] SYNC_RESET = {2'b00, KEY_IDLE};

  localparam logic [CNT_WIDTH-1:0] DB_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic                 REPEAT_EN   = (REPEAT_DELAY != 0);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  // Bit 0 = key (1 = pressed after normalisation), bits 2:1 = switches.
  logic [2:0]           sync1;
  logic [2:0]           sync2;
  logic [2:0]           norm;
  logic [2:0]           stable;
  logic [CNT_WIDTH-1:0] db_cnt [3];
  logic [2:0]           upd;
  logic                 key_rise;
  logic                 key_fall;
  rep_state_t           rep_state;
  logic [CNT_WIDTH-1:0] rep_cnt;

  // Two-flop synchroniser for all three raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= SYNC_RESET;
      sync2 <= SYNC_RESET;
    end else begin
      sync1 <= {sw_raw, key_raw};
      sync2 <= sync1;
    end
  end

  assign norm = {sync2[2:1], sync2[0] ^ KEY_IDLE};

  // A bit's stable value flips on the edge that completes its run of differing samples.
  always_comb begin
    upd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      upd[i] = (norm[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // Independent debounce counter per bit; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (norm[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= norm[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign key_rise = upd[0] & ~stable[0];
  assign key_fall = upd[0] & stable[0];
  assign key      = stable[0];
  assign sw       = stable[2:1];

  // Edge pulses registered alongside the stable value so they cover its first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      sw_changed   <= 1'b0;
    end else begin
      key_pressed  <= key_rise;
      key_released <= key_fall;
      sw_changed   <= |upd[2:1];
    end
  end

  // Hold-to-repeat: initial delay after the press, then a fixed period until release.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_state  <= IDLE;
      rep_cnt    <= '0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if (key_fall) begin
        rep_state <= IDLE;
        rep_cnt   <= '0;
      end else begin
        case (rep_state)
          IDLE: begin
            if (key_rise && REPEAT_EN) begin
              rep_state <= DELAY;
              rep_cnt   <= '0;
            end
          end
          DELAY: begin
            if (rep_cnt == DELAY_LAST) begin
              key_repeat <= 1'b1;
              rep_cnt    <= '0;
              rep_state  <= REPEAT;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (rep_cnt == PERIOD_LAST) begin
              key_repeat <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          default: begin
            rep_state <= IDLE;
            rep_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
